// File: rtl/idma_desc64_completion_tracker.sv
// idma_desc64_completion_tracker: per-channel in-flight descriptor queues with round-robin completion writeback
module idma_desc64_completion_tracker #(
    parameter int unsigned NumChannels      = 2,
    parameter int unsigned AddrWidth        = 64,
    parameter int unsigned PendingFifoDepth = 8,
    parameter int unsigned ChanIdxWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    parameter int unsigned CntWidth         = $clog2(PendingFifoDepth + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            push_valid_i,
    output logic                            push_ready_o,
    input  logic [ChanIdxWidth-1:0]         push_chan_i,
    input  logic [AddrWidth-1:0]            push_addr_i,
    input  logic                            push_irq_i,
    input  logic                            rsp_valid_i,
    output logic                            rsp_ready_o,
    input  logic [ChanIdxWidth-1:0]         rsp_chan_i,
    input  logic                            rsp_error_i,
    output logic                            wb_valid_o,
    input  logic                            wb_ready_i,
    output logic [AddrWidth-1:0]            wb_addr_o,
    output logic [ChanIdxWidth-1:0]         wb_chan_o,
    output logic                            wb_error_o,
    output logic                            wb_irq_o,
    output logic [NumChannels*CntWidth-1:0] pending_cnt_o,
    output logic                            busy_o
);
    localparam int unsigned IdxWidth = $clog2(PendingFifoDepth);
    localparam int unsigned PtrWidth = IdxWidth + 1;
    typedef logic [PtrWidth-1:0] ptr_t;

    ptr_t                 wr_q   [NumChannels];
    ptr_t                 done_q [NumChannels];
    ptr_t                 rd_q   [NumChannels];
    ptr_t                 occ    [NumChannels];
    logic [AddrWidth-1:0] addr_mem [NumChannels][PendingFifoDepth];
    logic                 irq_mem  [NumChannels][PendingFifoDepth];
    logic                 err_mem  [NumChannels][PendingFifoDepth];
    logic [NumChannels-1:0]  rsp_hit, elig;
    logic [ChanIdxWidth-1:0] rr_q, win, c_idx;
    logic push_chan_ok, rsp_chan_ok, push_fire, rsp_fire, load, win_found, win_err;

    assign push_chan_ok = 32'(push_chan_i) < NumChannels;
    assign rsp_chan_ok  = 32'(rsp_chan_i) < NumChannels;
    assign push_ready_o = push_chan_ok && (occ[push_chan_i] < PtrWidth'(PendingFifoDepth));
    assign rsp_ready_o  = rsp_chan_ok && (wr_q[rsp_chan_i] != done_q[rsp_chan_i]);
    assign push_fire    = push_valid_i && push_ready_o;
    assign rsp_fire     = rsp_valid_i && rsp_ready_o;
    assign load         = !wb_valid_o || wb_ready_i;
    assign busy_o       = wb_valid_o || (|pending_cnt_o);

    // A response accepted this cycle makes its channel eligible immediately
    always_comb begin
        rsp_hit       = '0;
        elig          = '0;
        pending_cnt_o = '0;
        for (int c = 0; c < NumChannels; c++) begin
            occ[c]     = wr_q[c] - rd_q[c];
            rsp_hit[c] = rsp_fire && (rsp_chan_i == ChanIdxWidth'(c));
            elig[c]    = (rd_q[c] != done_q[c]) || rsp_hit[c];
            pending_cnt_o[c*CntWidth +: CntWidth] = CntWidth'(occ[c]);
        end
    end

    always_comb begin
        win       = '0;
        win_found = 1'b0;
        c_idx     = rr_q;
        for (int i = 0; i < NumChannels; i++) begin
            c_idx = (32'(c_idx) == NumChannels - 1) ? '0 : c_idx + ChanIdxWidth'(1);
            if (!win_found && elig[c_idx]) begin
                win       = c_idx;
                win_found = 1'b1;
            end
        end
        win_err = (rd_q[win] == done_q[win]) ? rsp_error_i : err_mem[win][rd_q[win][IdxWidth-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            addr_mem[push_chan_i][wr_q[push_chan_i][IdxWidth-1:0]] <= push_addr_i;
            irq_mem[push_chan_i][wr_q[push_chan_i][IdxWidth-1:0]]  <= push_irq_i;
        end
        if (rsp_fire) err_mem[rsp_chan_i][done_q[rsp_chan_i][IdxWidth-1:0]] <= rsp_error_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NumChannels; c++) begin
                wr_q[c]   <= '0;
                done_q[c] <= '0;
                rd_q[c]   <= '0;
            end
            rr_q       <= '0;
            wb_valid_o <= 1'b0;
            wb_addr_o  <= '0;
            wb_chan_o  <= '0;
            wb_error_o <= 1'b0;
            wb_irq_o   <= 1'b0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                if (push_fire && push_chan_i == ChanIdxWidth'(c)) wr_q[c] <= wr_q[c] + PtrWidth'(1);
                if (rsp_hit[c]) done_q[c] <= done_q[c] + PtrWidth'(1);
                if (load && win_found && win == ChanIdxWidth'(c)) rd_q[c] <= rd_q[c] + PtrWidth'(1);
            end
            if (load) begin
                wb_valid_o <= win_found;
                if (win_found) begin
                    rr_q       <= win;
                    wb_addr_o  <= addr_mem[win][rd_q[win][IdxWidth-1:0]];
                    wb_chan_o  <= win;
                    wb_error_o <= win_err;
                    wb_irq_o   <= irq_mem[win][rd_q[win][IdxWidth-1:0]] | win_err;
                end
            end
        end
    end

    always_comb begin
        assert (!(push_valid_i && !push_chan_ok));
        assert (!(rsp_valid_i && !rsp_chan_ok));
    end
endmodule

// File: tb/tb_idma_desc64_completion_tracker.sv
// tb_idma_desc64_completion_tracker: directed checks of queueing, pairing, arbitration and reset
module tb_idma_desc64_completion_tracker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push_valid = 1'b0, push_irq = 1'b0, rsp_valid = 1'b0, rsp_error = 1'b0, wb_ready = 1'b0;
    logic        push_chan = 1'b0, rsp_chan = 1'b0;
    logic [63:0] push_addr = '0;
    logic        push_ready, rsp_ready, wb_valid, wb_error, wb_irq, busy, wb_chan;
    logic [63:0] wb_addr;
    logic [7:0]  pending_cnt;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    idma_desc64_completion_tracker dut (
        .clk_i(clk), .rst_ni(rst_n),
        .push_valid_i(push_valid), .push_ready_o(push_ready), .push_chan_i(push_chan),
        .push_addr_i(push_addr), .push_irq_i(push_irq),
        .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready), .rsp_chan_i(rsp_chan), .rsp_error_i(rsp_error),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_addr_o(wb_addr), .wb_chan_o(wb_chan),
        .wb_error_o(wb_error), .wb_irq_o(wb_irq), .pending_cnt_o(pending_cnt), .busy_o(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input string tag, input logic [63:0] addr, input logic chan, input logic err, input logic irq);
        check({tag, "_valid"}, 64'(wb_valid), 64'd1);
        check({tag, "_addr"}, wb_addr, addr);
        check({tag, "_chan"}, 64'(wb_chan), 64'(chan));
        check({tag, "_err"}, 64'(wb_error), 64'(err));
        check({tag, "_irq"}, 64'(wb_irq), 64'(irq));
    endtask

    task automatic push(input logic ch, input logic [63:0] addr, input logic irq);
        push_valid = 1'b1; push_chan = ch; push_addr = addr; push_irq = irq;
        #1;
        check("push_ready", 64'(push_ready), 64'd1);
        tick();
        push_valid = 1'b0;
    endtask

    task automatic rsp(input logic ch, input logic err);
        rsp_valid = 1'b1; rsp_chan = ch; rsp_error = err;
        #1;
        check("rsp_ready", 64'(rsp_ready), 64'd1);
        tick();
        rsp_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_addr [6];
        exp_addr = '{64'h4000, 64'h2008, 64'h4008, 64'h2010, 64'h4010, 64'h2018};
        tick();
        tick();
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_addr", wb_addr, 64'd0);
        check("rst_pending", 64'(pending_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // single descriptor round trip
        push(1'b0, 64'h1000, 1'b0);
        check("t1_pending", 64'(pending_cnt), 64'h01);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_no_wb", 64'(wb_valid), 64'd0);
        rsp(1'b0, 1'b0);
        check_wb("t1_wb", 64'h1000, 1'b0, 1'b0, 1'b0);
        check("t1_pending_after", 64'(pending_cnt), 64'h00);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("t1_wb_drop", 64'(wb_valid), 64'd0);
        check("t1_busy_fall", 64'(busy), 64'd0);

        // fill channel 1, then free one slot
        for (int i = 0; i < 8; i++) push(1'b1, 64'h2000 + 64'(8 * i), 1'b0);
        check("t2_pending_full", 64'(pending_cnt), 64'h80);
        push_valid = 1'b1; push_chan = 1'b0; push_addr = 64'h9999;
        #1;
        check("t2_ch0_ready", 64'(push_ready), 64'd1);
        push_chan = 1'b1; push_addr = 64'h2040;
        rsp_valid = 1'b1; rsp_chan = 1'b1; rsp_error = 1'b0;
        #1;
        check("t2_ch1_full", 64'(push_ready), 64'd0);
        check("t2_rsp_ready", 64'(rsp_ready), 64'd1);
        tick();
        rsp_valid = 1'b0;
        #1;
        check("t2_ch1_freed", 64'(push_ready), 64'd1);
        check("t2_pending_7", 64'(pending_cnt), 64'h70);
        check_wb("t2_wb", 64'h2000, 1'b1, 1'b0, 1'b0);
        wb_ready = 1'b1;
        tick();
        push_valid = 1'b0; wb_ready = 1'b0;
        check("t2_wb_drop", 64'(wb_valid), 64'd0);
        check("t2_pending_refill", 64'(pending_cnt), 64'h80);

        // response with nothing outstanding on channel 0 stalls
        rsp_valid = 1'b1; rsp_chan = 1'b0; rsp_error = 1'b0;
        push_valid = 1'b1; push_chan = 1'b0; push_addr = 64'h3000; push_irq = 1'b0;
        #1;
        check("t3_rsp_stall", 64'(rsp_ready), 64'd0);
        check("t3_push_ready", 64'(push_ready), 64'd1);
        tick();
        push_valid = 1'b0;
        #1;
        check("t3_rsp_ready", 64'(rsp_ready), 64'd1);
        tick();
        rsp_valid = 1'b0;
        check_wb("t3_wb", 64'h3000, 1'b0, 1'b0, 1'b0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;

        // round-robin alternation
        push(1'b0, 64'h4000, 1'b0);
        push(1'b0, 64'h4008, 1'b0);
        push(1'b0, 64'h4010, 1'b0);
        for (int i = 0; i < 6; i++) rsp(1'(i % 2), 1'b0);
        wb_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("t4_valid", 64'(wb_valid), 64'd1);
            check("t4_chan", 64'(wb_chan), 64'(i % 2));
            check("t4_addr", wb_addr, exp_addr[i]);
            tick();
        end
        check("t4_drain", 64'(wb_valid), 64'd0);
        wb_ready = 1'b0;
        check("t4_pending", 64'(pending_cnt), 64'h50);

        // error forces irq, outputs hold under backpressure
        push(1'b0, 64'h5000, 1'b0);
        rsp(1'b0, 1'b1);
        check_wb("t5_wb", 64'h5000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            push_valid = (i == 0); push_chan = 1'b0; push_addr = 64'h5008; push_irq = 1'b1;
            rsp_valid = (i == 1); rsp_chan = 1'b0; rsp_error = 1'b0;
            tick();
            check_wb("t5_hold", 64'h5000, 1'b0, 1'b1, 1'b1);
        end
        push_valid = 1'b0; rsp_valid = 1'b0;
        wb_ready = 1'b1;
        tick();
        check_wb("t5_next", 64'h5008, 1'b0, 1'b0, 1'b1);
        tick();
        wb_ready = 1'b0;
        check("t5_drain", 64'(wb_valid), 64'd0);

        // asynchronous reset mid-operation
        rsp(1'b1, 1'b0);
        check_wb("t6_pre", 64'h2020, 1'b1, 1'b0, 1'b0);
        rsp_valid = 1'b1; rsp_chan = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_wb_valid", 64'(wb_valid), 64'd0);
        check("t6_wb_addr", wb_addr, 64'd0);
        check("t6_wb_chan", 64'(wb_chan), 64'd0);
        check("t6_wb_err", 64'(wb_error), 64'd0);
        check("t6_wb_irq", 64'(wb_irq), 64'd0);
        check("t6_pending", 64'(pending_cnt), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_rsp_ready", 64'(rsp_ready), 64'd0);
        #1;
        rst_n = 1'b1;
        push_valid = 1'b1; push_chan = 1'b1; push_addr = 64'h6000; push_irq = 1'b0;
        #1;
        check("t6_push_ready", 64'(push_ready), 64'd1);
        check("t6_rsp_stall", 64'(rsp_ready), 64'd0);
        tick();
        push_valid = 1'b0;
        check("t6_pending_1", 64'(pending_cnt), 64'h10);
        #1;
        check("t6_rsp_ready_after", 64'(rsp_ready), 64'd1);
        tick();
        rsp_valid = 1'b0;
        check_wb("t6_wb", 64'h6000, 1'b1, 1'b0, 1'b0);
        check("t6_pending_0", 64'(pending_cnt), 64'h00);
        wb_ready = 1'b1;
        tick();
        check("t6_busy_end", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
